// File: rtl/bsg_round_robin_burst_arb.sv
// ---------------------------------------------------------------------------
// bsg_round_robin_burst_arb
//
// Shares one valid/ready output channel among els_p requesters. The grant is
// chosen round-robin when idle. It is then held from the first beat of a
// burst until the beat flagged last is accepted, so bursts from different
// requesters never interleave on the output. An optional cap (max_burst_p)
// cuts a burst that runs too long. On the cut beat, last_o is forced high and
// overrun_o pulses for one cycle.
//
// Ports
//   clk_i      : clock, all state updates on posedge
//   reset_n_i  : synchronous reset, active-low
//   v_i        : per-requester valid
//   data_i     : per-requester data, slice i = data_i[i*width_p +: width_p]
//   last_i     : per-requester "this beat ends the burst"
//   yumi_o     : one-hot, beat from requester i consumed this cycle
//   v_o        : output valid (independent of ready_i)
//   data_o     : data of the selected requester
//   last_o     : last flag of the selected beat (forced high on a capped beat)
//   tag_o      : index of the requester driving data_o
//   ready_i    : downstream ready
//   overrun_o  : one-cycle pulse when a burst is cut at max_burst_p
// ---------------------------------------------------------------------------
module bsg_round_robin_burst_arb #(
    parameter int els_p       = 4,
    parameter int width_p     = 32,
    parameter int max_burst_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    input  logic [els_p-1:0]           last_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic                       last_o,
    output logic [$clog2(els_p)-1:0]   tag_o,
    input  logic                       ready_i,
    output logic                       overrun_o
);

    localparam int tag_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = (max_burst_p > 0) ? $clog2(max_burst_p + 1) : 1;
    localparam bit cap_en_lp = (max_burst_p != 0);
    localparam logic [cnt_w_lp-1:0] cap_lp = cnt_w_lp'(max_burst_p);
    localparam logic [tag_w_lp-1:0] last_idx_lp = tag_w_lp'(els_p - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [tag_w_lp-1:0]   owner_q, owner_d;
    logic [tag_w_lp-1:0]   prio_q, prio_d;
    logic [cnt_w_lp-1:0]   beat_cnt_q, beat_cnt_d;

    logic [width_p-1:0]    data_arr [els_p];
    logic                  rr_found;
    logic [tag_w_lp-1:0]   rr_sel;
    logic [tag_w_lp-1:0]   scan_idx;
    logic [tag_w_lp-1:0]   sel;
    logic                  v_sel;
    logic                  last_sel;
    logic [cnt_w_lp-1:0]   beat_cnt_inc;
    logic                  cap_hit;
    logic                  accept;

    // -----------------------------------------------------------------------
    // Unpack the flat data bus so the output mux is a plain array index.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            data_arr[i] = data_i[i*width_p +: width_p];
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first valid requester starting at prio_q, wrapping.
    // Only consulted in IDLE; LOCKED always selects the burst owner.
    // -----------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = prio_q;
        scan_idx = prio_q;
        for (int k = 0; k < els_p; k++) begin
            scan_idx = tag_w_lp'((int'(prio_q) + k) % els_p);
            if (!rr_found && v_i[scan_idx]) begin
                rr_found = 1'b1;
                rr_sel   = scan_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and handshake.
    // -----------------------------------------------------------------------
    always_comb begin
        sel          = (state_q == LOCKED) ? owner_q : rr_sel;
        v_sel        = v_i[sel];
        last_sel     = last_i[sel];
        beat_cnt_inc = beat_cnt_q + 1'b1;

        // The cap only cuts a burst that would otherwise continue.
        cap_hit      = cap_en_lp && !last_sel && (beat_cnt_inc == cap_lp);

        // Outputs are forced quiet while reset is asserted.
        v_o          = reset_n_i & v_sel;
        accept       = v_o & ready_i;

        data_o       = data_arr[sel];
        last_o       = last_sel | cap_hit;
        tag_o        = sel;
        overrun_o    = accept & cap_hit;

        yumi_o       = '0;
        if (accept) begin
            yumi_o[sel] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Nothing moves unless a beat is accepted, so a stalled
    // or bubbling owner keeps the lock and the beat count.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        beat_cnt_d = beat_cnt_q;

        if (accept) begin
            if (last_sel || cap_hit) begin
                // Burst ends (naturally or by the cap): release the lane and
                // give the requester after the owner top priority.
                state_d    = IDLE;
                prio_d     = (sel == last_idx_lp) ? '0 : sel + 1'b1;
                beat_cnt_d = '0;
            end else begin
                state_d    = LOCKED;
                owner_d    = sel;
                // With no cap the count is never needed, so it stays at zero
                // instead of wrapping.
                beat_cnt_d = cap_en_lp ? beat_cnt_inc : '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            prio_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake sanity: consume at most one beat, and only from a requester
    // that is actually presenting one.
    // -----------------------------------------------------------------------
    a_yumi_onehot : assert property (@(posedge clk_i) $onehot0(yumi_o));
    a_yumi_has_v  : assert property (@(posedge clk_i) (yumi_o & ~v_i) == '0);

endmodule

// File: tb/tb_bsg_round_robin_burst_arb.sv
// ---------------------------------------------------------------------------
// Directed bench for bsg_round_robin_burst_arb (els_p=4, width_p=32,
// max_burst_p=4). Inputs change on the falling edge and outputs are compared
// 1 ns later, well away from the rising edge that updates the arbiter.
//
// Expected-output encoding used by the per-test tables (9 bits):
//   [8] v_o  [7:4] yumi_o  [3:2] tag_o  [1] last_o  [0] overrun_o
// When the expected v_o is 0, tag_o/last_o/data_o are not compared.
// Data for requester r on beat b is 32'hD000_0000 | r<<8 | b.
// ---------------------------------------------------------------------------
module tb_bsg_round_robin_burst_arb;

    localparam int ELS  = 4;
    localparam int W    = 32;
    localparam int MAXB = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [ELS-1:0]     v_i;
    logic [ELS*W-1:0]   data_i;
    logic [ELS-1:0]     last_i;
    logic [ELS-1:0]     yumi_o;
    logic               v_o;
    logic [W-1:0]       data_o;
    logic               last_o;
    logic [1:0]         tag_o;
    logic               ready_i;
    logic               overrun_o;

    int checks   = 0;
    int failures = 0;

    bsg_round_robin_burst_arb #(
        .els_p      (ELS),
        .width_p    (W),
        .max_burst_p(MAXB)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .v_i      (v_i),
        .data_i   (data_i),
        .last_i   (last_i),
        .yumi_o   (yumi_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .tag_o    (tag_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dval(input int r, input int b);
        return 32'hD000_0000 | 32'(r << 8) | 32'(b);
    endfunction

    // Apply one cycle of stimulus on the falling edge, then let it settle.
    task automatic drive(input logic rst_n, input logic [3:0] v, input logic [3:0] l,
                         input logic rdy, input int beat);
        @(negedge clk);
        reset_n = rst_n;
        v_i     = v;
        last_i  = l;
        ready_i = rdy;
        for (int i = 0; i < ELS; i++) data_i[i*W +: W] = dval(i, beat);
        #1;
    endtask

    // Hold reset across one rising edge; the next drive() releases it.
    task automatic do_reset();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 0);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic       rs  [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] tv  [3] = '{4'b1111, 4'b1111, 4'b1111};
        logic [3:0] tl  [3] = '{4'b0000, 4'b0000, 4'b0000};
        int         tbt [3] = '{0, 1, 2};
        logic [8:0] te  [3] = '{9'b0_0000_00_0_0, 9'b0_0000_00_0_0, 9'b1_0001_00_0_0};
        for (int c = 0; c < 3; c++) begin
            drive(rs[c], tv[c], tl[c], 1'b1, tbt[c]);
            checks++;
            if (te[c][8] ? ({v_o, yumi_o, tag_o, last_o, overrun_o} !== te[c] ||
                            data_o !== dval(int'(te[c][3:2]), tbt[c]))
                         : ({v_o, yumi_o, overrun_o} !== {te[c][8:4], te[c][0]})) begin
                failures++;
                $display("FAIL reset[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, te[c],
                         dval(int'(te[c][3:2]), tbt[c]));
            end
        end
    endtask

    // All four requesting single-beat bursts: strict rotation 0,1,2,3,0,...
    task automatic test_rr_rotation();
        logic [8:0] exp_v;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'b1111, 4'b1111, 1'b1, c);
            exp_v = {1'b1, 4'(1 << (c % 4)), 2'(c % 4), 1'b1, 1'b0};
            checks++;
            if ({v_o, yumi_o, tag_o, last_o, overrun_o} !== exp_v ||
                data_o !== dval(c % 4, c)) begin
                failures++;
                $display("FAIL rr_rotation[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, exp_v, dval(c % 4, c));
            end
        end
    endtask

    // Req1 3-beat burst while req2 waits; req2 only after req1's last beat.
    task automatic test_burst_lock();
        logic [3:0] tv  [4] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110};
        logic [3:0] tl  [4] = '{4'b0100, 4'b0100, 4'b0110, 4'b0100};
        int         tbt [4] = '{0, 1, 2, 3};
        logic [8:0] te  [4] = '{9'b1_0010_01_0_0, 9'b1_0010_01_0_0,
                                9'b1_0010_01_1_0, 9'b1_0100_10_1_0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, tv[c], tl[c], 1'b1, tbt[c]);
            checks++;
            if (te[c][8] ? ({v_o, yumi_o, tag_o, last_o, overrun_o} !== te[c] ||
                            data_o !== dval(int'(te[c][3:2]), tbt[c]))
                         : ({v_o, yumi_o, overrun_o} !== {te[c][8:4], te[c][0]})) begin
                failures++;
                $display("FAIL burst_lock[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, te[c],
                         dval(int'(te[c][3:2]), tbt[c]));
            end
        end
    endtask

    // Locked on req0 with ready low for 4 cycles: nothing moves, no count.
    task automatic test_backpressure();
        logic       tr  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] tv  [7] = '{4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
        logic [3:0] tl  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1001};
        int         tbt [7] = '{0, 1, 1, 1, 1, 1, 2};
        logic [8:0] te  [7] = '{9'b1_0001_00_0_0, 9'b1_0000_00_0_0, 9'b1_0000_00_0_0,
                                9'b1_0000_00_0_0, 9'b1_0000_00_0_0, 9'b1_0001_00_1_0,
                                9'b1_1000_11_1_0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, tv[c], tl[c], tr[c], tbt[c]);
            checks++;
            if (te[c][8] ? ({v_o, yumi_o, tag_o, last_o, overrun_o} !== te[c] ||
                            data_o !== dval(int'(te[c][3:2]), tbt[c]))
                         : ({v_o, yumi_o, overrun_o} !== {te[c][8:4], te[c][0]})) begin
                failures++;
                $display("FAIL backpressure[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, te[c],
                         dval(int'(te[c][3:2]), tbt[c]));
            end
        end
    endtask

    // Req2 sends 6 beats, no last, nobody else valid: cut at beat 4, then
    // req2 wins again and starts a fresh count.
    task automatic test_overrun_same();
        logic [8:0] te  [6] = '{9'b1_0100_10_0_0, 9'b1_0100_10_0_0, 9'b1_0100_10_0_0,
                                9'b1_0100_10_1_1, 9'b1_0100_10_0_0, 9'b1_0100_10_0_0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 4'b0100, 4'b0000, 1'b1, c);
            checks++;
            if ({v_o, yumi_o, tag_o, last_o, overrun_o} !== te[c] ||
                data_o !== dval(2, c)) begin
                failures++;
                $display("FAIL overrun_same[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, te[c], dval(2, c));
            end
        end
    endtask

    // Same cut, but req3 becomes valid during the burst: it is held off until
    // the cap releases the lane, then wins.
    task automatic test_overrun_handoff();
        logic [3:0] tv  [5] = '{4'b0100, 4'b1100, 4'b1100, 4'b1100, 4'b1100};
        logic [8:0] te  [5] = '{9'b1_0100_10_0_0, 9'b1_0100_10_0_0, 9'b1_0100_10_0_0,
                                9'b1_0100_10_1_1, 9'b1_1000_11_0_0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, tv[c], 4'b0000, 1'b1, c);
            checks++;
            if ({v_o, yumi_o, tag_o, last_o, overrun_o} !== te[c] ||
                data_o !== dval(int'(te[c][3:2]), c)) begin
                failures++;
                $display("FAIL overrun_handoff[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, te[c],
                         dval(int'(te[c][3:2]), c));
            end
        end
    endtask

    // Owner req1 bubbles for 2 cycles while req0 waits; req1 then resumes.
    task automatic test_owner_bubble();
        logic [3:0] tv  [5] = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0011};
        logic [3:0] tl  [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0011};
        int         tbt [5] = '{0, 1, 1, 1, 2};
        logic [8:0] te  [5] = '{9'b1_0010_01_0_0, 9'b0_0000_00_0_0, 9'b0_0000_00_0_0,
                                9'b1_0010_01_1_0, 9'b1_0001_00_1_0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, tv[c], tl[c], 1'b1, tbt[c]);
            checks++;
            if (te[c][8] ? ({v_o, yumi_o, tag_o, last_o, overrun_o} !== te[c] ||
                            data_o !== dval(int'(te[c][3:2]), tbt[c]))
                         : ({v_o, yumi_o, overrun_o} !== {te[c][8:4], te[c][0]})) begin
                failures++;
                $display("FAIL owner_bubble[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, te[c],
                         dval(int'(te[c][3:2]), tbt[c]));
            end
        end
    endtask

    // Reset in the middle of a req3 burst drops the lock and priority.
    task automatic test_reset_mid_burst();
        logic       rs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] tv  [4] = '{4'b1000, 4'b1000, 4'b1111, 4'b1111};
        logic [3:0] tl  [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
        int         tbt [4] = '{0, 1, 2, 3};
        logic [8:0] te  [4] = '{9'b1_1000_11_0_0, 9'b1_1000_11_0_0,
                                9'b0_0000_00_0_0, 9'b1_0001_00_1_0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(rs[c], tv[c], tl[c], 1'b1, tbt[c]);
            checks++;
            if (te[c][8] ? ({v_o, yumi_o, tag_o, last_o, overrun_o} !== te[c] ||
                            data_o !== dval(int'(te[c][3:2]), tbt[c]))
                         : ({v_o, yumi_o, overrun_o} !== {te[c][8:4], te[c][0]})) begin
                failures++;
                $display("FAIL reset_mid_burst[%0d]: got v=%b yumi=%b tag=%0d last=%b ovr=%b data=%h, want %b data=%h",
                         c, v_o, yumi_o, tag_o, last_o, overrun_o, data_o, te[c],
                         dval(int'(te[c][3:2]), tbt[c]));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        v_i     = '0;
        last_i  = '0;
        ready_i = 1'b0;
        data_i  = '0;

        test_reset();
        test_rr_rotation();
        test_burst_lock();
        test_backpressure();
        test_overrun_same();
        test_overrun_handoff();
        test_owner_bubble();
        test_reset_mid_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
